xalu_nibble_seq: RTL and testbench
==================================

# xalu_nibble_seq

Nibble-serial sequencer that runs multi-nibble word operations through the team's single 4-bit ALU slice. It latches two word operands and a function code, then feeds the slice one nibble per clock. Carry and shift bits are chained between nibbles through an internal register. Per-nibble results and status are collected into a word result with word-level carry, zero, negative-zero and equality flags. The block sits between the requester (start/done handshake) and the combinational ALU slice, which it drives through its `alu_*` ports.

## Interface
Parameters:
- `NIBBLES`, default 4: word width = 4*NIBBLES bits. Legal range 1..8.

Ports (W = 4*NIBBLES):
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `start`  in  1  request; accepted only in IDLE
- `op`  in  3  function code: 0 ADD, 1 AND, 2 OR, 3 XOR, 4 PASSA, 5 PASSB, 6 SHR, 7 SHL
- `com`  in  1  ones-complement output mode, passed to the slice
- `cin`  in  1  ADD carry-in / SHL shift-in (bit 0) / SHR shift-in (bit W-1)
- `opa`, `opb`  in  W  word operands
- `busy`  out  1  high in RUN and DONE
- `done`  out  1  one-cycle completion pulse
- `result`  out  W  word result, held until the next accepted start
- `cout`  out  1  final carry or shifted-out bit
- `zero`, `neg_zero`, `equ`  out  1  word flags: all result bits 0; all result bits 1; opa==opb
- `alu_a`, `alu_b`  out  4  nibble operands to the slice
- `alu_f`  out  3  function code to the slice
- `alu_com`  out  1  complement mode to the slice
- `alu_ci_right`, `alu_ci_left`  out  1  slice carry inputs
- `alu_d`  in  4  slice data output
- `alu_co_left`, `alu_co_right`  in  1  slice carry outputs
- `alu_zero`, `alu_neg_zero`, `alu_equ`  in  1  slice status outputs

## Operation
- States: IDLE, RUN, DONE.
- **IDLE:**
  - `start`=1 latches `opa`, `opb`, `op`, `com`, `cin`, then moves to RUN.
  - `carry_q` ← `cin`.
  - Nibble index: NIBBLES-1 for SHR; 0 for every other op.
  - `zero_acc`, `neg_acc`, `equ_acc` ← 1.
- **RUN:** one nibble per cycle.
  - Slice drive: `alu_a`/`alu_b` = latched nibble[idx]; `alu_f` = latched op; `alu_com` = latched com.
  - ADD and SHL: `alu_ci_right` = `carry_q`, `alu_ci_left` = 0.
  - SHR: `alu_ci_left` = `carry_q`, `alu_ci_right` = 0.
  - Ops 1–5: both carry inputs = 0.
  - At each edge:
    - `result` nibble[idx] ← `alu_d`.
    - `carry_q` ← `alu_co_left` for ADD/SHL, `alu_co_right` for SHR, 0 otherwise.
    - Flag accumulators are AND-ed with `alu_zero`, `alu_neg_zero`, `alu_equ`.
  - Index steps +1 (or −1 for SHR). After the NIBBLES-th nibble, go to DONE.
- **DONE:** `done`=1 for exactly one cycle, then IDLE.
  - `cout`/`zero`/`neg_zero`/`equ` are updated from the final accumulators on the edge entering DONE.
  - `result` is fully written on the same edge.
- **Idle slice drive:** when not in RUN, all `alu_*` outputs = 0.
- **Word-level semantics:**
  - ADD = `opa`+`opb`+`cin` mod 2^W, `cout` = carry out of bit W-1.
  - SHL: `result` = {`opa`[W-2:0], `cin`}, `cout` = `opa`[W-1].
  - SHR: `result` = {`cin`, `opa`[W-1:1]}, `cout` = `opa`[0].
  - Ops 1–5: bitwise/pass, `cout` = 0.
- **`com`** inverts `result` bits only; it does not affect `cout`. `zero`/`neg_zero` reflect the inverted result.
- **`start` while `busy`:** ignored, no effect on the operation in flight. Input changes during RUN are ignored (latched copies are used).
- **Reset:** `rst_n`=0 at any edge, including mid-RUN, forces IDLE. Every output becomes 0: `busy`, `done`, `result`, `cout`, `zero`, `neg_zero`, `equ`, all `alu_*`. No `done` is issued for an aborted operation.

## Timing
- `start` sampled at edge T0.
- RUN occupies cycles T0+1 … T0+NIBBLES; the slice path is combinational within each cycle.
- `done`=1 in cycle T0+NIBBLES+1, which is also the cycle `busy` is last high.
- The earliest next start accepted is at edge T0+NIBBLES+2 (IDLE re-entered).
- Latency start→done = NIBBLES+1 cycles; throughput one op per NIBBLES+2 cycles.
- `start` held continuously → back-to-back ops every NIBBLES+2 cycles.
- Outputs are registered, except `alu_*`, which decode from registered state and latched operands.

## Test plan
All with NIBBLES=4 and the real ALU slice attached to the `alu_*` ports.
- ADD `opa`=0xFFFF, `opb`=0x0001, `cin`=0, `com`=0 → `result`=0x0000, `cout`=1, `zero`=1, `equ`=0; `done` exactly 5 cycles after start, `busy` 5 cycles.
- SHR `opa`=0x8001, `cin`=1 → `result`=0xC000, `cout`=1. SHL `opa`=0x8001, `cin`=0 → `result`=0x0002, `cout`=1.
- XOR `opa`=`opb`=0x1234, `com`=1 → `result`=0xFFFF, `neg_zero`=1, `zero`=0, `equ`=1, `cout`=0.
- ADD 0x1234+0x4321, then pulse `start` with different operands during RUN → `result`=0x5555, `cout`=0; no second `done` until a start is sampled in IDLE.
- Start ADD, drop `rst_n` in the 2nd RUN cycle → next cycle: IDLE, all outputs 0, no `done`. A subsequent ADD 0x0008+0x0008 → `result`=0x0010.

Source files
------------

// File: rtl/xalu_nibble_seq.sv
// xalu_nibble_seq: nibble-serial word sequencer driving a 4-bit ALU slice
module xalu_nibble_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [2:0]           op,
    input  logic                 com,
    input  logic                 cin,
    input  logic [4*NIBBLES-1:0] opa,
    input  logic [4*NIBBLES-1:0] opb,
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] result,
    output logic                 cout,
    output logic                 zero,
    output logic                 neg_zero,
    output logic                 equ,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic [2:0]           alu_f,
    output logic                 alu_com,
    output logic                 alu_ci_right,
    output logic                 alu_ci_left,
    input  logic [3:0]           alu_d,
    input  logic                 alu_co_left,
    input  logic                 alu_co_right,
    input  logic                 alu_zero,
    input  logic                 alu_neg_zero,
    input  logic                 alu_equ
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [2:0] OP_ADD = 3'd0, OP_SHR = 3'd6, OP_SHL = 3'd7;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [W-1:0]   opa_q, opa_d, opb_q, opb_d, result_q, result_d;
    logic [2:0]     op_q, op_d;
    logic           com_q, com_d, carry_q, carry_d;
    logic           zacc_q, zacc_d, nacc_q, nacc_d, eacc_q, eacc_d;
    logic           cout_q, cout_d, zero_q, zero_d, neg_zero_q, neg_zero_d, equ_q, equ_d;
    logic           run, chain_left, chain_right, last;

    assign run         = state_q == RUN;
    assign chain_left  = op_q == OP_ADD || op_q == OP_SHL;
    assign chain_right = op_q == OP_SHR;
    assign last        = chain_right ? idx_q == '0 : idx_q == IW'(NIBBLES - 1);

    assign alu_a        = run ? opa_q[4*idx_q +: 4] : 4'h0;
    assign alu_b        = run ? opb_q[4*idx_q +: 4] : 4'h0;
    assign alu_f        = run ? op_q : 3'd0;
    assign alu_com      = run && com_q;
    assign alu_ci_right = run && chain_left && carry_q;
    assign alu_ci_left  = run && chain_right && carry_q;

    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign result   = result_q;
    assign cout     = cout_q;
    assign zero     = zero_q;
    assign neg_zero = neg_zero_q;
    assign equ      = equ_q;

    // Next state: latch on start, fold one slice result per RUN cycle, publish flags on the last nibble
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        op_d       = op_q;
        com_d      = com_q;
        carry_d    = carry_q;
        zacc_d     = zacc_q;
        nacc_d     = nacc_q;
        eacc_d     = eacc_q;
        result_d   = result_q;
        cout_d     = cout_q;
        zero_d     = zero_q;
        neg_zero_d = neg_zero_q;
        equ_d      = equ_q;
        case (state_q)
            IDLE: if (start) begin
                state_d = RUN;
                opa_d   = opa;
                opb_d   = opb;
                op_d    = op;
                com_d   = com;
                carry_d = cin;
                idx_d   = (op == OP_SHR) ? IW'(NIBBLES - 1) : '0;
                zacc_d  = 1'b1;
                nacc_d  = 1'b1;
                eacc_d  = 1'b1;
            end
            RUN: begin
                result_d[4*idx_q +: 4] = alu_d;
                carry_d = chain_left ? alu_co_left : chain_right ? alu_co_right : 1'b0;
                zacc_d  = zacc_q & alu_zero;
                nacc_d  = nacc_q & alu_neg_zero;
                eacc_d  = eacc_q & alu_equ;
                idx_d   = chain_right ? idx_q - 1'b1 : idx_q + 1'b1;
                if (last) begin
                    state_d    = DONE;
                    cout_d     = carry_d;
                    zero_d     = zacc_d;
                    neg_zero_d = nacc_d;
                    equ_d      = eacc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset clearing every output-visible flop
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            op_q       <= '0;
            com_q      <= 1'b0;
            carry_q    <= 1'b0;
            zacc_q     <= 1'b0;
            nacc_q     <= 1'b0;
            eacc_q     <= 1'b0;
            result_q   <= '0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
            neg_zero_q <= 1'b0;
            equ_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            op_q       <= op_d;
            com_q      <= com_d;
            carry_q    <= carry_d;
            zacc_q     <= zacc_d;
            nacc_q     <= nacc_d;
            eacc_q     <= eacc_d;
            result_q   <= result_d;
            cout_q     <= cout_d;
            zero_q     <= zero_d;
            neg_zero_q <= neg_zero_d;
            equ_q      <= equ_d;
        end
    end
endmodule

// File: tb/tb_xalu_nibble_seq.sv
// tb_xalu_nibble_seq: directed vector bench with a behavioural 4-bit ALU slice attached
module tb_xalu_nibble_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic        com = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] opa = 16'h0, opb = 16'h0;
    logic        busy, done, cout, zero, neg_zero, equ;
    logic [15:0] result;
    logic [3:0]  alu_a, alu_b, alu_d;
    logic [2:0]  alu_f;
    logic        alu_com, alu_ci_right, alu_ci_left;
    logic        alu_co_left, alu_co_right, alu_zero, alu_neg_zero, alu_equ;
    logic [4:0]  s_sum;
    logic [3:0]  s_raw;
    int          tests = 0;
    int          fails = 0;

    xalu_nibble_seq #(.NIBBLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .com(com), .cin(cin),
        .opa(opa), .opb(opb), .busy(busy), .done(done), .result(result), .cout(cout),
        .zero(zero), .neg_zero(neg_zero), .equ(equ), .alu_a(alu_a), .alu_b(alu_b),
        .alu_f(alu_f), .alu_com(alu_com), .alu_ci_right(alu_ci_right), .alu_ci_left(alu_ci_left),
        .alu_d(alu_d), .alu_co_left(alu_co_left), .alu_co_right(alu_co_right),
        .alu_zero(alu_zero), .alu_neg_zero(alu_neg_zero), .alu_equ(alu_equ)
    );

    always #5 clk = ~clk;

    // Slice model: ADD/logic/pass/shift on one nibble, com inverts data only
    always_comb begin
        s_sum        = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci_right};
        s_raw        = 4'h0;
        alu_co_left  = 1'b0;
        alu_co_right = 1'b0;
        case (alu_f)
            3'd0: begin s_raw = s_sum[3:0]; alu_co_left = s_sum[4]; end
            3'd1: s_raw = alu_a & alu_b;
            3'd2: s_raw = alu_a | alu_b;
            3'd3: s_raw = alu_a ^ alu_b;
            3'd4: s_raw = alu_a;
            3'd5: s_raw = alu_b;
            3'd6: begin s_raw = {alu_ci_left, alu_a[3:1]}; alu_co_right = alu_a[0]; end
            default: begin s_raw = {alu_a[2:0], alu_ci_right}; alu_co_left = alu_a[3]; end
        endcase
        alu_d        = alu_com ? ~s_raw : s_raw;
        alu_zero     = alu_d == 4'h0;
        alu_neg_zero = alu_d == 4'hF;
        alu_equ      = alu_a == alu_b;
    end

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic        com;
        logic        cin;
        logic [15:0] opa;
        logic [15:0] opb;
        logic [15:0] res;
        logic        cout;
        logic        zero;
        logic        nz;
        logic        equ;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic run_op(input vec_t v, input logic scramble_mid);
        int n = 0;
        int busy_n = 0;
        bit seen = 0;
        @(negedge clk);
        op = v.op; com = v.com; cin = v.cin; opa = v.opa; opb = v.opb; start = 1'b1;
        @(posedge clk);
        while (n < 20 && !seen) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0;
                opa = ~v.opa; opb = v.opa ^ 16'h5A5A; op = v.op + 3'd1; cin = ~v.cin; com = ~v.com;
            end
            if (scramble_mid && n == 2) begin start = 1'b1; opa = 16'hFFFF; opb = 16'hFFFF; end
            if (scramble_mid && n == 3) start = 1'b0;
            if (busy) busy_n++;
            if (done) seen = 1;
        end
        chk({v.name, " done_seen"}, 32'(seen), 32'd1);
        chk({v.name, " latency"}, 32'(n), 32'd5);
        chk({v.name, " busy_cycles"}, 32'(busy_n), 32'd5);
        chk({v.name, " result"}, 32'(result), 32'(v.res));
        chk({v.name, " cout"}, 32'(cout), 32'(v.cout));
        chk({v.name, " zero"}, 32'(zero), 32'(v.zero));
        chk({v.name, " neg_zero"}, 32'(neg_zero), 32'(v.nz));
        chk({v.name, " equ"}, 32'(equ), 32'(v.equ));
        @(negedge clk);
        chk({v.name, " done_pulse_end"}, 32'(done), 32'd0);
        chk({v.name, " idle_busy"}, 32'(busy), 32'd0);
        chk({v.name, " result_held"}, 32'(result), 32'(v.res));
    endtask

    initial begin
        vecs[0]  = '{"add_wrap",   3'd0, 1'b0, 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{"shr",        3'd6, 1'b0, 1'b1, 16'h8001, 16'h0000, 16'hC000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{"shl",        3'd7, 1'b0, 1'b0, 16'h8001, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{"xor_com",    3'd3, 1'b1, 1'b0, 16'h1234, 16'h1234, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{"add_plain",  3'd0, 1'b0, 1'b0, 16'h1234, 16'h4321, 16'h5555, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{"and_cin",    3'd1, 1'b0, 1'b1, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{"or",         3'd2, 1'b0, 1'b0, 16'h1200, 16'h0034, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{"passa",      3'd4, 1'b0, 1'b0, 16'hABCD, 16'h1234, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{"passb",      3'd5, 1'b0, 1'b0, 16'h0000, 16'h5A5A, 16'h5A5A, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{"add_cin",    3'd0, 1'b0, 1'b1, 16'h7FFF, 16'h0000, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{"passa_com",  3'd4, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b1};
        vecs[11] = '{"and_zero",   3'd1, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[12] = '{"shr_out",    3'd6, 1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0};

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset result", 32'(result), 32'd0);
        chk("reset flags", {28'd0, cout, zero, neg_zero, equ}, 32'd0);
        chk("reset alu", {14'd0, alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left}, 32'd0);

        foreach (vecs[i]) run_op(vecs[i], 1'b0);

        run_op(vecs[4], 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("no_second_done", 32'(done | busy), 32'd0);
        end

        @(negedge clk);
        op = 3'd0; com = 1'b0; cin = 1'b0; opa = 16'h1111; opb = 16'h2222; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk("abort run busy", 32'(busy), 32'd1);
        chk("abort alu_f", 32'(alu_f), 32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort done", 32'(done), 32'd0);
        chk("abort result", 32'(result), 32'd0);
        chk("abort flags", {28'd0, cout, zero, neg_zero, equ}, 32'd0);
        chk("abort alu", {14'd0, alu_a, alu_b, alu_f, alu_com, alu_ci_right, alu_ci_left}, 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("abort no_done", 32'(done | busy), 32'd0);
        end
        run_op('{"add_after_abort", 3'd0, 1'b0, 1'b0, 16'h0008, 16'h0008, 16'h0010, 1'b0, 1'b0, 1'b0, 1'b1}, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
